// File: rtl/dot_sched_pkg.sv
// Shared types and constants for the dot-product lane scheduler.
// Holds the scheduler state type and the element data width.
package dot_sched_pkg;

    localparam int DOT_DW = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIST    = 2'd1,
        COLLECT = 2'd2
    } sched_state_t;

endpackage

// File: rtl/dot_lane_join.sv
// Joins per-lane result valids into one valid and fans the downstream ready back
// to every lane at once, so a partial set of results is never acknowledged.
module lane_join #(
    parameter int LANES = 4
) (
    input  logic             enable,
    input  logic [LANES-1:0] res_tvalid,
    input  logic             join_tready,
    output logic             join_tvalid,
    output logic [LANES-1:0] res_tready
);

    assign join_tvalid = enable & (&res_tvalid);
    assign res_tready  = {LANES{join_tvalid & join_tready}};

endmodule

// File: rtl/dot_lane_scheduler.sv
// Round-robin distributor of an input vector across LANES dot lanes, then joins
// COLS result beats per vector. Optional stall counter under DOT_SCHED_PERF_EN.
module dot_lane_scheduler
    import dot_sched_pkg::*;
#(
    parameter int LANES = 4,
    parameter int ROWS  = 8,
    parameter int COLS  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DOT_DW-1:0]             INPUT_AXIS_TDATA,
    input  logic                          INPUT_AXIS_TLAST,
    input  logic                          INPUT_AXIS_TVALID,
    output logic                          INPUT_AXIS_TREADY,
    output logic [LANES-1:0][DOT_DW-1:0]  lane_tdata,
    output logic [LANES-1:0]              lane_tlast,
    output logic [LANES-1:0]              lane_tvalid,
    input  logic [LANES-1:0]              lane_tready,
    input  logic [LANES-1:0]              res_tvalid,
    output logic [LANES-1:0]              res_tready,
    output logic                          join_tvalid,
    input  logic                          join_tready,
    output logic                          busy,
    output logic                          done,
    output logic                          err_tlast,
    output logic [31:0]                   stall_cycles
);

    localparam int KW = $clog2(ROWS);
    localparam int CW = $clog2(COLS) + 1;
    localparam int SW = $clog2(LANES);

    localparam logic [KW-1:0] K_LAST = KW'(ROWS - 1);
    localparam logic [KW-1:0] K_TAIL = KW'(ROWS - LANES);
    localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);

    generate
        if (ROWS % LANES != 0) begin : g_rows_check
            $error("dot_lane_scheduler: ROWS must be a multiple of LANES");
        end
        if (LANES < 2 || (LANES & (LANES - 1)) != 0) begin : g_lanes_check
            $error("dot_lane_scheduler: LANES must be a power of two >= 2");
        end
    endgenerate

    sched_state_t  state;
    logic [KW-1:0] k;
    logic [CW-1:0] c;
    logic [SW-1:0] sel;
    logic          xfer;
    logic          join_hs;

    // Lanes are powers of two, so the low bits of k select the lane.
    assign sel     = k[SW-1:0];
    assign xfer    = (state == DIST) & INPUT_AXIS_TVALID & lane_tready[sel];
    assign join_hs = join_tvalid & join_tready;
    assign busy    = (state != IDLE);
    assign done    = join_hs & (c == C_LAST);

    lane_join #(
        .LANES (LANES)
    ) u_join (
        .enable      (state == COLLECT),
        .res_tvalid  (res_tvalid),
        .join_tready (join_tready),
        .join_tvalid (join_tvalid),
        .res_tready  (res_tready)
    );

    always_comb begin
        lane_tdata        = '0;
        lane_tvalid       = '0;
        lane_tlast        = '0;
        INPUT_AXIS_TREADY = 1'b0;
        if (state == DIST) begin
            lane_tdata[sel]   = INPUT_AXIS_TDATA;
            lane_tvalid[sel]  = INPUT_AXIS_TVALID;
            lane_tlast[sel]   = (k >= K_TAIL);
            INPUT_AXIS_TREADY = lane_tready[sel];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            c         <= '0;
            err_tlast <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (INPUT_AXIS_TVALID) begin
                        state <= DIST;
                        k     <= '0;
                    end
                end
                DIST: begin
                    if (xfer) begin
                        // TLAST must coincide exactly with the final element.
                        if (INPUT_AXIS_TLAST != (k == K_LAST)) begin
                            err_tlast <= 1'b1;
                        end
                        if (k == K_LAST) begin
                            state <= COLLECT;
                            k     <= '0;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (join_hs) begin
                        if (c == C_LAST) begin
                            state <= IDLE;
                            c     <= '0;
                        end else begin
                            c <= c + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DOT_SCHED_PERF_EN
    logic stall_event;
    assign stall_event = ((state == DIST) & INPUT_AXIS_TVALID & ~lane_tready[sel])
                       | (join_tvalid & ~join_tready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall_event && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`else
    assign stall_cycles = '0;
`endif

endmodule
